// File: rtl/uart_rx_os.sv
// Oversampling UART receive engine: 8N1 or 8-parity-1 frames sampled at mid-bit,
// one byte per frame with ready pulse, parity and framing status.
module uart_rx_os #(
   parameter int OS         = 16,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       rx,
   output logic [7:0] d,
   output logic       dr,
   output logic       pb,
   output logic       perr,
   output logic       ferr
);

   localparam int CW = $clog2(OS);
   localparam logic [CW-1:0] HALF = CW'(OS / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OS - 1);
   localparam logic PE = (PARITY_EN != 0);
   localparam logic PO = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bi;
   logic [7:0]      sh;
   logic            par;
   logic            s1;
   logic            rxs;
   logic            pbit;

   assign pbit = PE & par;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         bi    <= '0;
         sh    <= '0;
         par   <= 1'b0;
         s1    <= 1'b1;
         rxs   <= 1'b1;
         d     <= '0;
         dr    <= 1'b0;
         pb    <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         s1  <= rx;
         rxs <= s1;
         dr  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (cnt == HALF) begin
                     cnt   <= '0;
                     bi    <= '0;
                     // a glitch that is gone by mid start bit is ignored
                     state <= rxs ? IDLE : DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (cnt == LAST) begin
                     sh[bi] <= rxs;
                     cnt    <= '0;
                     bi     <= bi + 3'd1;
                     if (bi == 3'd7)
                        state <= PE ? PARITY : STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  if (cnt == LAST) begin
                     par   <= rxs;
                     cnt   <= '0;
                     state <= STOP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (cnt == LAST) begin
                     d     <= sh;
                     pb    <= pbit;
                     perr  <= PE & ((^{sh, pbit}) != PO);
                     ferr  <= ~rxs;
                     dr    <= 1'b1;
                     cnt   <= '0;
                     // a low stop bit is a break: wait for the line to idle
                     state <= rxs ? IDLE : BREAK;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: even- and odd-parity receivers share one line,
// frames are driven bit by bit and the status is compared to hand values.
`timescale 1ns/1ps
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] d_e, d_o;
   logic       dr_e, pb_e, perr_e, ferr_e;
   logic       dr_o, pb_o, perr_o, ferr_o;

   int checks = 0;
   int errors = 0;
   int per = 1;
   int tcnt = 0;
   int ec = 0;
   int nd = 0;
   int nd_o = 0;
   int dr_ec = 0;
   int t0 = 0;
   int n0 = 0;
   logic [7:0] cap_d [16];
   logic [7:0] cap_prev [16];
   logic [7:0] pd = 8'h00;

   always #5 clk = ~clk;

   uart_rx_os #(.OS(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
      .clk(clk), .rst(rst), .tick(tick), .rx(rx),
      .d(d_e), .dr(dr_e), .pb(pb_e), .perr(perr_e), .ferr(ferr_e)
   );

   uart_rx_os #(.OS(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
      .clk(clk), .rst(rst), .tick(tick), .rx(rx),
      .d(d_o), .dr(dr_o), .pb(pb_o), .perr(perr_o), .ferr(ferr_o)
   );

   always @(posedge clk) ec <= ec + 1;

   always @(negedge clk) begin
      if (dr_e) begin
         if (nd < 16) begin
            cap_d[nd]    = d_e;
            cap_prev[nd] = pd;
         end
         nd++;
         dr_ec = ec;
      end
      if (dr_o)
         nd_o++;
      pd = d_e;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tcnt++;
         tick = (tcnt % per == 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wt(input int n);
      repeat (n) begin
         @(posedge clk);
         while (tick !== 1'b1)
            @(posedge clk);
      end
      #1;
   endtask

   task automatic frame(input logic [7:0] b, input logic p,
                        input logic stp, input int nst);
      rx = 1'b0;
      t0 = ec;
      wt(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wt(16);
      end
      rx = p;
      wt(16);
      rx = stp;
      wt(nst);
      rx = 1'b1;
   endtask

   initial begin
      repeat (4) @(posedge clk);
      #1;
      chk("rst_d", d_e, 8'h00);
      chk("rst_dr", dr_e, 1'b0);
      chk("rst_pb", pb_e, 1'b0);
      chk("rst_perr", perr_e, 1'b0);
      chk("rst_ferr", ferr_e, 1'b0);
      rst = 1'b0;
      wt(4);

      n0 = nd;
      frame(8'h55, 1'b0, 1'b1, 16);
      wt(4);
      chk("f55_cnt", nd - n0, 1);
      chk("f55_d", d_e, 8'h55);
      chk("f55_pb", pb_e, 1'b0);
      chk("f55_perr", perr_e, 1'b0);
      chk("f55_ferr", ferr_e, 1'b0);
      chk("f55_perr_odd", perr_o, 1'b1);
      // 2 sync flops + detect edge + 8 + 16*10 ticks
      chk("f55_lat", dr_ec - t0, 171);

      frame(8'hA3, 1'b1, 1'b1, 16);
      wt(4);
      chk("fa3_d", d_e, 8'hA3);
      chk("fa3_pb", pb_e, 1'b1);
      chk("fa3_perr", perr_e, 1'b1);
      chk("fa3_perr_odd", perr_o, 1'b0);
      chk("fa3_ferr", ferr_e, 1'b0);

      n0 = nd;
      rx = 1'b0;
      wt(4);
      rx = 1'b1;
      wt(30);
      chk("false_start", nd - n0, 0);
      frame(8'h3C, 1'b0, 1'b1, 16);
      wt(4);
      chk("f3c_cnt", nd - n0, 1);
      chk("f3c_d", d_e, 8'h3C);
      chk("f3c_perr", perr_e, 1'b0);

      n0 = nd;
      frame(8'h81, 1'b0, 1'b0, 40);
      wt(40);
      chk("brk_cnt", nd - n0, 1);
      chk("brk_d", d_e, 8'h81);
      chk("brk_ferr", ferr_e, 1'b1);
      chk("brk_perr", perr_e, 1'b0);
      frame(8'h7E, 1'b0, 1'b1, 16);
      wt(4);
      chk("f7e_cnt", nd - n0, 2);
      chk("f7e_d", d_e, 8'h7E);
      chk("f7e_ferr", ferr_e, 1'b0);

      n0 = nd;
      rx = 1'b0;
      wt(16);
      for (int i = 0; i < 5; i++) begin
         rx = i[0];
         wt(16);
      end
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_d", d_e, 8'h00);
      chk("mid_rst_flags", {dr_e, pb_e, perr_e, ferr_e}, 4'h0);
      chk("mid_rst_d_odd", d_o, 8'h00);
      rst = 1'b0;
      wt(30);
      chk("mid_rst_nodr", nd - n0, 0);
      frame(8'hF0, 1'b0, 1'b1, 16);
      wt(4);
      chk("ff0_cnt", nd - n0, 1);
      chk("ff0_d", d_e, 8'hF0);
      chk("ff0_flags", {pb_e, perr_e, ferr_e}, 3'h0);

      per = 3;
      wt(4);
      n0 = nd;
      frame(8'h12, 1'b0, 1'b1, 16);
      chk("b2b_first", d_e, 8'h12);
      frame(8'h34, 1'b1, 1'b1, 16);
      wt(4);
      chk("b2b_cnt", nd - n0, 2);
      chk("b2b_d0", cap_d[n0], 8'h12);
      chk("b2b_d1", cap_d[n0 + 1], 8'h34);
      chk("b2b_hold", cap_prev[n0 + 1], 8'h12);
      chk("b2b_perr", perr_e, 1'b0);
      chk("b2b_pb", pb_e, 1'b1);
      chk("odd_cnt", nd_o, nd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
